uart_tx_shifter: RTL and testbench
==================================

// Module: uart_tx_shifter
// PURPOSE
//  UART transmit framer/shifter. Sits directly upstream of bit_counter_tx: takes bytes over a
//  valid/ready handshake, drives shift_en into the counter and serialises one 10-bit frame
//  (start 0, 8 data LSB-first, stop 1) on txd, one bit per baud_tick.
//  Ends a frame on the counter's done pulse. A one-entry holding buffer lets the next byte
//  be accepted while the current frame is being sent. A watchdog aborts a frame that never completes.
// PARAMETERS
//  DATA_W      8   data bits per frame; fixed at 8, matching bit_counter_tx's 10-bit count
//  WDOG_TICKS  12  baud ticks in SHIFT without bit_done before abort; must be >= 11
// PORTS
//  clk        in   1  system clock
//  rst        in   1  reset, asynchronous, active-high
//  baud_tick  in   1  one-clk pulse per bit period
//  tx_data    in   8  byte to send, sampled when tx_valid && tx_ready
//  tx_valid   in   1  tx_data valid
//  tx_ready   out  1  holding buffer empty; equals !hold_valid
//  bit_done   in   1  done pulse from bit_counter_tx
//  shift_en   out  1  frame in progress; drives bit_counter_tx.shift_en
//  txd        out  1  serial line, idles 1
//  busy       out  1  (state != IDLE) || hold_valid
//  wdog_err   out  1  one-clk pulse on watchdog abort
// BEHAVIOUR
//  Reset (async): state=IDLE, hold_valid=0, sreg=10'h3FF, wdog_cnt=0. Outputs: tx_ready=1,
//   shift_en=0, txd=1, busy=0, wdog_err=0. Reset mid-frame: txd returns to 1 at once, frame is lost.
//  Accept: tx_valid && tx_ready at edge N -> hold_data=tx_data, hold_valid=1, tx_ready=0 at N+1.
//   No accept is possible while hold_valid=1.
//  All outputs are registered. txd = sreg[0].
//  FSM:
//   IDLE:  if hold_valid -> ARM. shift_en=0.
//   ARM:   wait for baud_tick with shift_en=0. On that tick: sreg <= {1'b1, hold_data, 1'b0};
//          hold_valid <= 0; shift_en <= 1; wdog_cnt <= 0; -> SHIFT.
//          The start bit is therefore tick-aligned and lasts a full bit period.
//   SHIFT: shift_en=1.
//          On baud_tick: sreg <= {1'b1, sreg[9:1]}; wdog_cnt++.
//          On bit_done: shift_en <= 0, sreg <= 10'h3FF -> IDLE. bit_done wins over a same-cycle
//          baud_tick (no shift).
//          If wdog_cnt == WDOG_TICKS with no bit_done: wdog_err <= 1 for one clk,
//          shift_en <= 0, sreg <= 10'h3FF -> IDLE. The held byte, if any, is kept.
//  Counter alignment: bit_counter_tx clears on the shift_en rising edge and ignores a tick in
//   that cycle. The first counted tick is the first tick after SHIFT entry. That tick ends the
//   start bit, and the 10th tick ends the stop bit. bit_done arrives 1 clk after the 10th tick,
//   when sreg is already 3FF, so txd stays 1.
//  Back-to-back frames: SHIFT->IDLE->ARM keeps shift_en low for at least 2 clks, which guarantees
//   a fresh rising edge to the counter. The next start bit begins on the first tick after ARM entry.
//  bit_done outside SHIFT is ignored. baud_tick in IDLE is ignored.
//  tx_ready may re-assert during SHIFT, once ARM has emptied the holding buffer.
//  wdog_cnt width is $clog2(WDOG_TICKS+1) and saturates; it never wraps.
// STRUCTURE
//  Shared package uart_pkg: FRAME_W=10, START_BIT=1'b0, STOP_BIT=1'b1, IDLE_LEVEL=1'b1, and a
//   localparam/typedef for the state encoding (IDLE, ARM, SHIFT).
//  Single module, no sub-module. Holding buffer, FSM, shift register and watchdog are each
//   small and tightly coupled.
//  Integration: top wires shift_en to the counter's shift_en, and the counter's done to bit_done.
// TESTING
//  Bench instantiates this block together with bit_counter_tx; baud_tick every 16 clks.
//  1 Send 8'hA5 -> txd = 0,1,0,1,0,0,1,0,1,1, each held 16 clks; one bit_done; shift_en falls
//    1 clk after it; busy=0 afterwards.
//  2 Send 8'h00, then 8'hFF while the first frame is in SHIFT -> second byte is accepted
//    (tx_ready=1 after ARM). Frames go out back-to-back, shift_en low >= 2 clks between them,
//    both frames bit-exact.
//  3 Hold tx_valid with hold_valid=1 -> tx_ready=0, tx_data changes are ignored, byte order
//    is preserved.
//  4 Tie bit_done to 0, send 8'h3C -> wdog_err pulses once after 12 ticks in SHIFT;
//    shift_en=0, txd=1, state IDLE.
//  5 Assert rst asynchronously on the 4th data bit -> txd=1, shift_en=0, tx_ready=1 without
//    waiting for clk. After release, 8'h81 is sent correctly.
//  6 Force baud_tick and bit_done in the same clk during SHIFT -> no shift occurs, the frame
//    ends, txd=1.

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART framing constants and the transmit FSM state encoding.
package uart_pkg;

    localparam int   FRAME_W    = 10;
    localparam logic START_BIT  = 1'b0;
    localparam logic STOP_BIT   = 1'b1;
    localparam logic IDLE_LEVEL = 1'b1;

    localparam logic [FRAME_W-1:0] SREG_IDLE = {FRAME_W{IDLE_LEVEL}};

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ARM   = 2'd1,
        ST_SHIFT = 2'd2
    } tx_state_e;

endpackage

// File: rtl/uart_tx_shifter.sv
// UART transmit framer: one-entry holding buffer feeding a 10-bit start/data/stop shifter,
// framed by bit_counter_tx's done pulse and guarded by a baud-tick watchdog.
module uart_tx_shifter
    import uart_pkg::*;
#(
    parameter int DATA_W     = 8,
    parameter int WDOG_TICKS = 12
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              baud_tick,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output logic              tx_ready,
    input  logic              bit_done,
    output logic              shift_en,
    output logic              txd,
    output logic              busy,
    output logic              wdog_err
);

    localparam int              WDOG_W     = $clog2(WDOG_TICKS + 1);
    localparam logic [WDOG_W-1:0] WDOG_LIMIT = WDOG_W'(WDOG_TICKS);

    tx_state_e           state_q, state_d;
    logic                hold_valid_q, hold_valid_d;
    logic [DATA_W-1:0]   hold_data_q, hold_data_d;
    logic [FRAME_W-1:0]  sreg_q, sreg_d;
    logic                shift_en_q, shift_en_d;
    logic [WDOG_W-1:0]   wdog_cnt_q, wdog_cnt_d;
    logic                wdog_err_q, wdog_err_d;
    logic                busy_q, busy_d;

    always_comb begin
        state_d      = state_q;
        hold_valid_d = hold_valid_q;
        hold_data_d  = hold_data_q;
        sreg_d       = sreg_q;
        shift_en_d   = shift_en_q;
        wdog_cnt_d   = wdog_cnt_q;
        wdog_err_d   = 1'b0;

        // The buffer is only writable when empty, and ARM only drains it when full,
        // so accept and drain never collide in the same cycle.
        if (tx_valid && !hold_valid_q) begin
            hold_data_d  = tx_data;
            hold_valid_d = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                shift_en_d = 1'b0;
                if (hold_valid_q) begin
                    state_d = ST_ARM;
                end
            end
            ST_ARM: begin
                shift_en_d = 1'b0;
                if (baud_tick) begin
                    sreg_d       = {STOP_BIT, hold_data_q, START_BIT};
                    hold_valid_d = 1'b0;
                    shift_en_d   = 1'b1;
                    wdog_cnt_d   = '0;
                    state_d      = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                shift_en_d = 1'b1;
                if (bit_done) begin
                    shift_en_d = 1'b0;
                    sreg_d     = SREG_IDLE;
                    state_d    = ST_IDLE;
                end else if (wdog_cnt_q == WDOG_LIMIT) begin
                    wdog_err_d = 1'b1;
                    shift_en_d = 1'b0;
                    sreg_d     = SREG_IDLE;
                    state_d    = ST_IDLE;
                end else if (baud_tick) begin
                    sreg_d     = {IDLE_LEVEL, sreg_q[FRAME_W-1:1]};
                    wdog_cnt_d = wdog_cnt_q + 1'b1;
                end
            end
            default: begin
                shift_en_d = 1'b0;
                sreg_d     = SREG_IDLE;
                state_d    = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE) || hold_valid_d;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            hold_valid_q <= 1'b0;
            hold_data_q  <= '0;
            sreg_q       <= SREG_IDLE;
            shift_en_q   <= 1'b0;
            wdog_cnt_q   <= '0;
            wdog_err_q   <= 1'b0;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            hold_valid_q <= hold_valid_d;
            hold_data_q  <= hold_data_d;
            sreg_q       <= sreg_d;
            shift_en_q   <= shift_en_d;
            wdog_cnt_q   <= wdog_cnt_d;
            wdog_err_q   <= wdog_err_d;
            busy_q       <= busy_d;
        end
    end

    assign tx_ready = !hold_valid_q;
    assign shift_en = shift_en_q;
    assign txd      = sreg_q[0];
    assign busy     = busy_q;
    assign wdog_err = wdog_err_q;

endmodule

// File: tb/tb_uart_tx_shifter.sv
// Directed bench for uart_tx_shifter with a behavioural bit_counter_tx and a 16-clk baud tick.
module tb_uart_tx_shifter;

    logic       clk = 1'b0;
    logic       rst;
    logic       baud_tick;
    logic [7:0] tx_data;
    logic       tx_valid;
    logic       tx_ready;
    logic       bit_done;
    logic       shift_en;
    logic       txd;
    logic       busy;
    logic       wdog_err;

    logic       tick_gen;
    logic       tick_force;
    logic       done_force;
    logic       done_sel;
    logic       model_done;
    logic [3:0] mcnt;
    logic       se_prev;

    int errors      = 0;
    int checks      = 0;
    int done_pulses = 0;
    int wdog_pulses = 0;

    always #5 clk = ~clk;

    assign baud_tick = tick_gen | tick_force;
    assign bit_done  = done_sel ? model_done : done_force;

    uart_tx_shifter dut (
        .clk       (clk),
        .rst       (rst),
        .baud_tick (baud_tick),
        .tx_data   (tx_data),
        .tx_valid  (tx_valid),
        .tx_ready  (tx_ready),
        .bit_done  (bit_done),
        .shift_en  (shift_en),
        .txd       (txd),
        .busy      (busy),
        .wdog_err  (wdog_err)
    );

    // bit_counter_tx: clears on shift_en rise (ignoring that cycle's tick), done 1 clk after 10th tick
    always @(posedge clk or posedge rst) begin
        if (rst) begin
            mcnt       <= 4'd0;
            se_prev    <= 1'b0;
            model_done <= 1'b0;
        end else begin
            se_prev    <= shift_en;
            model_done <= 1'b0;
            if (shift_en && !se_prev) begin
                mcnt <= 4'd0;
            end else if (shift_en && baud_tick) begin
                if (mcnt == 4'd9) begin
                    mcnt       <= 4'd0;
                    model_done <= 1'b1;
                end else begin
                    mcnt <= mcnt + 4'd1;
                end
            end
        end
    end

    always @(posedge clk) begin
        if (bit_done) done_pulses++;
        if (wdog_err) wdog_pulses++;
    end

    initial begin
        int div;
        div      = 0;
        tick_gen = 1'b0;
        forever begin
            @(negedge clk);
            tick_gen = (div == 15);
            div      = (div == 15) ? 0 : div + 1;
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        tx_data  = b;
        tx_valid = 1'b1;
        for (int k = 0; k < 400; k++) begin
            if (tx_ready) break;
            @(negedge clk);
        end
        checks++;
        if (tx_ready !== 1'b1) begin
            errors++;
            $display("FAIL send_%h_accept: tx_ready=%b required 1", b, tx_ready);
        end
        @(posedge clk);
        @(negedge clk);
        tx_valid = 1'b0;
        $display("send byte %h accepted at %0t", b, $time);
    endtask

    task automatic wait_shift_rise(input string tag, output int waited, output bit ok);
        ok     = 1'b0;
        waited = 0;
        for (int k = 0; k < 600; k++) begin
            tick(1);
            waited++;
            if (shift_en === 1'b1) begin
                ok = 1'b1;
                break;
            end
        end
        checks++;
        if (!ok) begin
            errors++;
            $display("FAIL %s_shift_en_rise: shift_en=%b required 1 within 600 clks", tag, shift_en);
        end
    endtask

    task automatic check_frame(input logic [7:0] b, input string tag, output int gap);
        logic [9:0] f;
        bit         ok;
        int         bad;
        f   = {1'b1, b, 1'b0};
        bad = 0;
        wait_shift_rise(tag, gap, ok);
        if (!ok) return;
        for (int i = 0; i < 10; i++) begin
            checks++;
            if (txd !== f[i]) begin
                errors++; bad++;
                $display("FAIL %s_bit%0d_head: txd=%b required %b", tag, i, txd, f[i]);
            end
            tick(15);
            checks++;
            if (txd !== f[i]) begin
                errors++; bad++;
                $display("FAIL %s_bit%0d_tail: txd=%b required %b", tag, i, txd, f[i]);
            end
            tick(1);
        end
        checks++;
        if (shift_en !== 1'b1 || txd !== 1'b1) begin
            errors++; bad++;
            $display("FAIL %s_after_stop: shift_en=%b txd=%b required 1 1", tag, shift_en, txd);
        end
        tick(1);
        checks++;
        if (shift_en !== 1'b0 || txd !== 1'b1) begin
            errors++; bad++;
            $display("FAIL %s_shift_en_fall: shift_en=%b txd=%b required 0 1", tag, shift_en, txd);
        end
        $display("frame %s byte %h gap=%0d bad=%0d", tag, b, gap, bad);
    endtask

    task automatic test_reset();
        tick(3);
        checks++;
        if (tx_ready !== 1'b1 || shift_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: ready=%b shift_en=%b txd=%b busy=%b wdog=%b required 1 0 1 0 0",
                     tx_ready, shift_en, txd, busy, wdog_err);
        end
        @(negedge clk);
        rst = 1'b0;
        tick(2);
        checks++;
        if (tx_ready !== 1'b1 || txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_idle: ready=%b txd=%b busy=%b required 1 1 0", tx_ready, txd, busy);
        end
        $display("reset checked");
    endtask

    task automatic test_single();
        int d0, w0, gap;
        d0 = done_pulses;
        w0 = wdog_pulses;
        send_byte(8'hA5);
        check_frame(8'hA5, "single", gap);
        checks++;
        if (done_pulses - d0 !== 1) begin
            errors++;
            $display("FAIL single_done_count: pulses=%0d required 1", done_pulses - d0);
        end
        checks++;
        if (busy !== 1'b0 || wdog_pulses != w0) begin
            errors++;
            $display("FAIL single_idle_after: busy=%b wdog_pulses=%0d required 0 %0d", busy, wdog_pulses, w0);
        end
    endtask

    task automatic test_back_to_back();
        int g0, g1, w;
        bit ok;
        send_byte(8'h00);
        fork
            begin
                check_frame(8'h00, "b2b_first", g0);
                check_frame(8'hFF, "b2b_second", g1);
            end
            begin
                wait_shift_rise("b2b_arm", w, ok);
                checks++;
                if (tx_ready !== 1'b1) begin
                    errors++;
                    $display("FAIL b2b_ready_in_shift: tx_ready=%b required 1", tx_ready);
                end
                send_byte(8'hFF);
                checks++;
                if (tx_ready !== 1'b0) begin
                    errors++;
                    $display("FAIL b2b_ready_after_accept: tx_ready=%b required 0", tx_ready);
                end
            end
        join
        checks++;
        if (g1 < 2) begin
            errors++;
            $display("FAIL b2b_gap: shift_en low clks=%0d required >=2", g1);
        end
    endtask

    task automatic test_hold_full();
        int g, w;
        bit ok;
        send_byte(8'h3A);
        fork
            begin
                check_frame(8'h3A, "hold_a", g);
                check_frame(8'hC5, "hold_b", g);
                check_frame(8'h5A, "hold_c", g);
            end
            begin
                wait_shift_rise("hold_arm", w, ok);
                send_byte(8'hC5);
                @(negedge clk);
                tx_data  = 8'h99;
                tx_valid = 1'b1;
                repeat (20) @(negedge clk);
                checks++;
                if (tx_ready !== 1'b0 || busy !== 1'b1) begin
                    errors++;
                    $display("FAIL hold_blocked: tx_ready=%b busy=%b required 0 1", tx_ready, busy);
                end
                send_byte(8'h5A);
            end
        join
    endtask

    task automatic test_watchdog();
        int w0, w;
        bit ok;
        done_sel   = 1'b0;
        done_force = 1'b0;
        w0 = wdog_pulses;
        send_byte(8'h3C);
        wait_shift_rise("wdog", w, ok);
        tick(192);
        checks++;
        if (wdog_err !== 1'b0 || shift_en !== 1'b1) begin
            errors++;
            $display("FAIL wdog_before: wdog_err=%b shift_en=%b required 0 1", wdog_err, shift_en);
        end
        tick(1);
        checks++;
        if (wdog_err !== 1'b1 || shift_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL wdog_abort: wdog_err=%b shift_en=%b txd=%b busy=%b required 1 0 1 0",
                     wdog_err, shift_en, txd, busy);
        end
        tick(1);
        checks++;
        if (wdog_err !== 1'b0 || wdog_pulses - w0 != 1) begin
            errors++;
            $display("FAIL wdog_single_pulse: wdog_err=%b pulses=%0d required 0 1", wdog_err, wdog_pulses - w0);
        end
        @(negedge clk);
        done_sel = 1'b1;
        $display("watchdog abort checked");
    endtask

    task automatic test_async_reset();
        int w, g;
        bit ok;
        send_byte(8'hE7);
        wait_shift_rise("arst", w, ok);
        tick(72);
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL arst_data_bit3: txd=%b required 0", txd);
        end
        #2;
        rst = 1'b1;
        #1;
        checks++;
        if (txd !== 1'b1 || shift_en !== 1'b0 || tx_ready !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL arst_immediate: txd=%b shift_en=%b tx_ready=%b busy=%b required 1 0 1 0",
                     txd, shift_en, tx_ready, busy);
        end
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        send_byte(8'h81);
        check_frame(8'h81, "post_rst", g);
    endtask

    task automatic test_tick_done_same_cycle();
        int w;
        bit ok;
        done_sel   = 1'b0;
        done_force = 1'b0;
        send_byte(8'hAA);
        wait_shift_rise("tie", w, ok);
        tick(3);
        checks++;
        if (txd !== 1'b0) begin
            errors++;
            $display("FAIL tie_start_bit: txd=%b required 0", txd);
        end
        @(negedge clk);
        tick_force = 1'b1;
        done_force = 1'b1;
        tick(1);
        checks++;
        if (shift_en !== 1'b0 || txd !== 1'b1 || busy !== 1'b0 || wdog_err !== 1'b0) begin
            errors++;
            $display("FAIL tie_done_wins: shift_en=%b txd=%b busy=%b wdog_err=%b required 0 1 0 0",
                     shift_en, txd, busy, wdog_err);
        end
        @(negedge clk);
        tick_force = 1'b0;
        done_force = 1'b0;
        done_sel   = 1'b1;
        tick(20);
        checks++;
        if (shift_en !== 1'b0 || txd !== 1'b1) begin
            errors++;
            $display("FAIL tie_stays_idle: shift_en=%b txd=%b required 0 1", shift_en, txd);
        end
        $display("tick/done collision checked");
    endtask

    initial begin
        rst        = 1'b1;
        tx_data    = 8'h00;
        tx_valid   = 1'b0;
        tick_force = 1'b0;
        done_force = 1'b0;
        done_sel   = 1'b1;

        test_reset();
        test_single();
        test_back_to_back();
        test_hold_full();
        test_watchdog();
        test_async_reset();
        test_tick_done_same_cycle();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
